// File: rtl/detect_pkg.sv
// Shared types and constants for the serial pattern detector.
package detect_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] DEFAULT_PATTERN = 3'b011;

endpackage

// File: rtl/detect_pattern_core.sv
// Overlapping 3-bit pattern matcher: bit history, saturating fill count, hit and registered Z.
module detect_pattern_core
  import detect_pkg::*;
#(
  parameter logic [2:0] PATTERN = DEFAULT_PATTERN
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_bit_valid,
  input  logic i_bit,
  input  logic i_clear,
  output logic o_hit,
  output logic o_z
);

  // The 3-bit window is the two stored bits plus the live bit.
  logic [1:0] r_hist;
  logic [1:0] r_fill;
  logic       r_z;

  assign o_hit = i_bit_valid & r_fill[1] & ({r_hist, i_bit} == PATTERN);
  assign o_z   = r_z;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hist <= 2'b00;
      r_fill <= 2'd0;
      r_z    <= 1'b0;
    end else begin
      r_z <= o_hit;
      if (i_clear) begin
        r_hist <= 2'b00;
        r_fill <= 2'd0;
      end else if (i_bit_valid) begin
        r_hist <= {r_hist[0], i_bit};
        if (r_fill != 2'd3) begin
          r_fill <= r_fill + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/detect_stream_sequencer.sv
// Word-to-serial sequencer feeding detect_pattern_core and counting matches per word.
// Build option DETECT_MATCH_SAT_EN: MatchCount saturates instead of wrapping.
module detect_stream_sequencer
  import detect_pkg::*;
#(
  parameter int         WIDTH   = 8,
  parameter logic [2:0] PATTERN = DEFAULT_PATTERN,
  parameter int         CNT_W   = 4
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DataIn,
  input  logic             DataValid,
  output logic             DataReady,
  input  logic             Clear,
  output logic             X,
  output logic             Z,
  output logic [CNT_W-1:0] MatchCount,
  output logic             Done
);

  localparam int BC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [BC_W-1:0]  r_bitcnt;
  logic [CNT_W-1:0] r_count;
  logic             r_done;

  logic             w_accept;
  logic             w_bit_valid;
  logic             w_clear;
  logic             w_hit;
  logic [CNT_W-1:0] w_count_inc;

  assign DataReady   = (r_state == IDLE);
  assign w_accept    = DataValid & DataReady;
  assign w_bit_valid = (r_state == SHIFT);
  assign w_clear     = Clear & (r_state == IDLE);
  assign X           = w_bit_valid & r_shift[WIDTH-1];
  assign MatchCount  = r_count;
  assign Done        = r_done;

`ifdef DETECT_MATCH_SAT_EN
  assign w_count_inc = (&r_count) ? r_count : r_count + CNT_W'(1);
`else
  assign w_count_inc = r_count + CNT_W'(1);
`endif

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_count  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift  <= DataIn;
            r_bitcnt <= BC_W'(WIDTH - 1);
            r_count  <= '0;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          r_shift  <= r_shift << 1;
          r_bitcnt <= r_bitcnt - BC_W'(1);
          if (w_hit) begin
            r_count <= w_count_inc;
          end
          // Last bit is on X this cycle; Done follows in the next one.
          if (r_bitcnt == '0) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  detect_pattern_core #(
    .PATTERN(PATTERN)
  ) u_core (
    .i_clk      (CLOCK),
    .i_rst_n    (RESET),
    .i_bit_valid(w_bit_valid),
    .i_bit      (X),
    .i_clear    (w_clear),
    .o_hit      (w_hit),
    .o_z        (Z)
  );

endmodule

// File: tb/tb_detect_stream_sequencer.sv
// Directed, table-driven bench for detect_stream_sequencer (default build and a PATTERN=000/CNT_W=2 instance).
module tb_detect_stream_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       clear;
  logic       x;
  logic       z;
  logic [3:0] match_count;
  logic       done;

  logic [7:0] data_in2;
  logic       data_valid2;
  logic       data_ready2;
  logic       clear2;
  logic       x2;
  logic       z2;
  logic [1:0] match_count2;
  logic       done2;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [7:0]  data;
    logic        clr;
    logic [3:0]  cnt;
    logic [11:0] zmask;
  } vec_t;

  vec_t vecs[11];

  detect_stream_sequencer dut (
    .CLOCK     (clk),
    .RESET     (rst_n),
    .DataIn    (data_in),
    .DataValid (data_valid),
    .DataReady (data_ready),
    .Clear     (clear),
    .X         (x),
    .Z         (z),
    .MatchCount(match_count),
    .Done      (done)
  );

  detect_stream_sequencer #(
    .WIDTH  (8),
    .PATTERN(3'b000),
    .CNT_W  (2)
  ) dut_sat (
    .CLOCK     (clk),
    .RESET     (rst_n),
    .DataIn    (data_in2),
    .DataValid (data_valid2),
    .DataReady (data_ready2),
    .Clear     (clear2),
    .X         (x2),
    .Z         (z2),
    .MatchCount(match_count2),
    .Done      (done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge with the word already driven; watches t+1..t+10.
  task automatic observe(input string nm, input logic [7:0] d, input logic [3:0] ecnt,
                         input logic [11:0] ez, input logic keep, input logic [7:0] nxt,
                         input logic nclr, input logic jclr);
    logic [11:0] zb, db, rb, xb, exb;
    logic [3:0]  cnt9, cnt10;
    zb = '0; db = '0; rb = '0; xb = '0; exb = '0; cnt9 = '0; cnt10 = '0;
    rb[0] = data_ready;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      zb[k] = z;
      db[k] = done;
      rb[k] = data_ready;
      xb[k] = x;
      if (k == 9)  cnt9  = match_count;
      if (k == 10) cnt10 = match_count;
      if (k < 10) begin
        data_in    = ~d ^ 8'(k);
        clear      = jclr;
        data_valid = keep;
      end else begin
        data_in    = nxt;
        clear      = nclr;
        data_valid = keep;
      end
    end
    for (int k = 1; k <= 8; k++) exb[k] = d[8-k];
    check({nm, ".x"},     xb, exb);
    check({nm, ".z"},     zb, ez);
    check({nm, ".done"},  db, 12'h200);
    check({nm, ".ready"}, rb, 12'h401);
    check({nm, ".count"}, 12'(cnt9), 12'(ecnt));
    check({nm, ".hold"},  12'(cnt10), 12'(ecnt));
    $display("[TB] word %s data=%08b count=%0d z=%03h", nm, d, cnt9, zb);
  endtask

  task automatic run_word(input string nm, input logic [7:0] d, input logic clr,
                          input logic [3:0] ecnt, input logic [11:0] ez);
    data_in    = d;
    clear      = clr;
    data_valid = 1'b1;
    observe(nm, d, ecnt, ez, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    logic [1:0] exp_sat;
    int         done_seen;
    n_tests = 0;
    n_fail  = 0;

    vecs[0]  = '{8'b0110_1100, 1'b1, 4'd2, 12'h090};
    vecs[1]  = '{8'b0000_0001, 1'b0, 4'd0, 12'h000};
    vecs[2]  = '{8'b1000_0000, 1'b0, 4'd1, 12'h004};
    vecs[3]  = '{8'b0000_0001, 1'b0, 4'd0, 12'h000};
    vecs[4]  = '{8'b1000_0000, 1'b1, 4'd0, 12'h000};
    vecs[5]  = '{8'b0011_0011, 1'b1, 4'd2, 12'h220};
    vecs[6]  = '{8'b1101_1011, 1'b0, 4'd2, 12'h240};
    vecs[7]  = '{8'b1111_1111, 1'b0, 4'd0, 12'h000};
    vecs[8]  = '{8'b0111_0111, 1'b0, 4'd2, 12'h110};
    vecs[9]  = '{8'b1100_0000, 1'b1, 4'd0, 12'h000};
    vecs[10] = '{8'b0110_0000, 1'b0, 4'd1, 12'h010};

    rst_n = 1'b0;
    data_in = 8'hA5; data_valid = 1'b1; clear = 1'b0;
    data_in2 = 8'h00; data_valid2 = 1'b0; clear2 = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst.x",     12'(x), 12'h0);
    check("rst.z",     12'(z), 12'h0);
    check("rst.done",  12'(done), 12'h0);
    check("rst.count", 12'(match_count), 12'h0);
    data_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rst.ready", 12'(data_ready), 12'h1);
    $display("[TB] reset released");

    // Saturation vs wrap on the PATTERN=000, CNT_W=2 instance: 6 hits in an all-zero word.
`ifdef DETECT_MATCH_SAT_EN
    exp_sat = 2'd3;
`else
    exp_sat = 2'd2;
`endif
    @(negedge clk);
    data_in2 = 8'h00; data_valid2 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      data_valid2 = 1'b0;
      if (k == 9) begin
        check("sat.done",  12'(done2), 12'h1);
        check("sat.count", 12'(match_count2), 12'(exp_sat));
        $display("[TB] word sat data=00 count=%0d", match_count2);
      end
    end

    // Table: history carries from row to row unless clr is set.
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      run_word($sformatf("vec%0d", i), vecs[i].data, vecs[i].clr, vecs[i].cnt, vecs[i].zmask);
    end

    // Back-to-back with DataValid held, junk DataIn and Clear=1 during SHIFT/DONE.
    data_in = 8'b0000_0001; clear = 1'b1; data_valid = 1'b1;
    observe("b2b_a", 8'b0000_0001, 4'd0, 12'h000, 1'b1, 8'b1000_0000, 1'b0, 1'b1);
    observe("b2b_b", 8'b1000_0000, 4'd1, 12'h004, 1'b0, 8'h00, 1'b0, 1'b0);

    // Reset mid-word at t+4, where Z and MatchCount would otherwise be 1.
    data_in = 8'b0110_1100; clear = 1'b0; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid.x",     12'(x), 12'h0);
    check("mid.z",     12'(z), 12'h0);
    check("mid.done",  12'(done), 12'h0);
    check("mid.count", 12'(match_count), 12'h0);
    check("mid.ready", 12'(data_ready), 12'h1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid.ready_after", 12'(data_ready), 12'h1);
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("mid.no_done", 12'(done_seen), 12'h0);
    $display("[TB] mid-word reset done_pulses=%0d", done_seen);
    run_word("post_rst", 8'b0110_1100, 1'b0, 4'd2, 12'h090);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
